// File: rtl/matrix_frame_tx.sv
// matrix_frame_tx: reads two operand matrices from a local element RAM and
// serialises them as a header/element/gap frame onto the loader byte bus.
module matrix_frame_tx #(
    parameter int MAX_DIM = 4,
    parameter int ADDR_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        dim_r1,
    input  logic [7:0]        dim_c1,
    input  logic [7:0]        dim_r2,
    input  logic [7:0]        dim_c2,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        data_send,
    output logic [1:0]        ctrl_logic
);
    localparam int NW = ADDR_W + 1;
    typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;
    state_t        r_state;
    logic [NW-1:0] r_cnt, r_n;
    logic [7:0]    r_r1, r_c1, r_r2, r_c2;
    logic          r_bad;
    logic          w_ok, w_acc;
    logic [NW-1:0] w_n, w_last;
    logic [7:0]    w_hdr;
    function automatic logic f_in(input logic [7:0] d);
        return d != 8'd0 && d <= 8'(MAX_DIM);
    endfunction
    assign w_ok   = f_in(dim_r1) && f_in(dim_c1) && f_in(dim_r2) && f_in(dim_c2) && dim_c1 == dim_r2;
    assign w_n    = NW'(dim_r1) * NW'(dim_c1) + NW'(dim_r2) * NW'(dim_c2);
    assign w_last = r_n - 1'b1;
    // The last gap beat doubles as an idle beat so frames can run back to back.
    assign w_acc  = start && (r_state == IDLE || (r_state == GAP && r_cnt[0]));
    assign w_hdr  = r_cnt[1:0] == 2'd0 ? r_r1 :
                    r_cnt[1:0] == 2'd1 ? r_c1 :
                    r_cnt[1:0] == 2'd2 ? r_r2 : r_c2;
    // Outputs trail the state by one beat; reads lead the data beats by two to cover RAM latency.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_n        <= '0;
            r_r1       <= '0;
            r_c1       <= '0;
            r_r2       <= '0;
            r_c2       <= '0;
            r_bad      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            data_send  <= '0;
            ctrl_logic <= 2'd2;
        end else begin
            err   <= r_bad;
            r_bad <= 1'b0;
            done  <= 1'b0;
            if (r_state == HDR && r_cnt == NW'(2)) begin
                rd_en   <= 1'b1;
                rd_addr <= '0;
            end else if (rd_en && {1'b0, rd_addr} != w_last) begin
                rd_addr <= rd_addr + 1'b1;
            end else begin
                rd_en   <= 1'b0;
                rd_addr <= '0;
            end
            case (r_state)
                IDLE: begin
                    ctrl_logic <= 2'd2;
                    data_send  <= '0;
                    busy       <= 1'b0;
                end
                HDR: begin
                    ctrl_logic <= 2'd1;
                    data_send  <= w_hdr;
                    busy       <= 1'b1;
                    r_cnt      <= r_cnt == NW'(3) ? '0 : r_cnt + 1'b1;
                    r_state    <= r_cnt == NW'(3) ? DATA : HDR;
                end
                DATA: begin
                    ctrl_logic <= 2'd0;
                    data_send  <= rd_data;
                    busy       <= 1'b1;
                    r_cnt      <= r_cnt == w_last ? '0 : r_cnt + 1'b1;
                    r_state    <= r_cnt == w_last ? GAP : DATA;
                end
                default: begin
                    ctrl_logic <= 2'd2;
                    data_send  <= '0;
                    busy       <= !r_cnt[0];
                    done       <= r_cnt[0];
                    r_cnt      <= r_cnt[0] ? '0 : NW'(1);
                    r_state    <= r_cnt[0] ? IDLE : GAP;
                end
            endcase
            if (w_acc) begin
                if (w_ok) begin
                    r_state <= HDR;
                    r_cnt   <= '0;
                    r_n     <= w_n;
                    r_r1    <= dim_r1;
                    r_c1    <= dim_c1;
                    r_r2    <= dim_r2;
                    r_c2    <= dim_c2;
                end else begin
                    r_bad <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_matrix_frame_tx.sv
// tb_matrix_frame_tx: directed frame, back-to-back, illegal-dimension and reset checks.
module tb_matrix_frame_tx;
    logic       CLK = 1'b0, RST = 1'b1, start = 1'b0;
    logic [7:0] dim_r1 = '0, dim_c1 = '0, dim_r2 = '0, dim_c2 = '0;
    logic       busy, done, err, rd_en;
    logic [4:0] rd_addr;
    logic [7:0] rd_data = '0, data_send;
    logic [1:0] ctrl_logic;
    logic [7:0] mem [0:31];
    int         n_vec = 0, n_err = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) if (rd_en) rd_data <= mem[rd_addr];

    matrix_frame_tx #(.MAX_DIM(4), .ADDR_W(5)) dut (
        .CLK(CLK), .RST(RST), .start(start),
        .dim_r1(dim_r1), .dim_c1(dim_c1), .dim_r2(dim_r2), .dim_c2(dim_c2),
        .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .data_send(data_send), .ctrl_logic(ctrl_logic)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic set_dims(input logic [31:0] d);
        {dim_r1, dim_c1, dim_r2, dim_c2} = d;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 32; i++) mem[i] = base + 8'(i);
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_ctrl"}, ctrl_logic, 2);
        chk({tag, "_data"}, data_send, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rden"}, rd_en, 0);
        chk({tag, "_addr"}, rd_addr, 0);
    endtask

    // Checks beats 1..stop of a frame; d packs R1,C1,R2,C2; post is what the
    // dim inputs show after accept; skip0 means the accept edge already happened.
    task automatic frame(input logic [31:0] d, input bit skip0, input bit hold,
                         input logic [31:0] post, input int last);
        logic [7:0] h [4];
        int n, stop, exp_d;
        {h[0], h[1], h[2], h[3]} = d;
        n = h[0] * h[1] + h[2] * h[3];
        stop = last == 0 ? 6 + n : last;
        if (!skip0) begin
            set_dims(d);
            start = 1'b1;
            tick();
        end
        start = hold;
        set_dims(post);
        tick();
        for (int t = 1; t <= stop; t++) begin
            if (t <= 4) exp_d = h[t-1];
            else if (t <= 4 + n) exp_d = mem[t-5];
            else exp_d = 0;
            chk($sformatf("ctrl@%0d", t), ctrl_logic, t <= 4 ? 1 : t <= 4 + n ? 0 : 2);
            chk($sformatf("data@%0d", t), data_send, exp_d);
            chk($sformatf("busy@%0d", t), busy, t <= 5 + n ? 1 : 0);
            chk($sformatf("done@%0d", t), done, t == 6 + n ? 1 : 0);
            chk($sformatf("err@%0d", t), err, 0);
            chk($sformatf("rden@%0d", t), rd_en, (t >= 3 && t <= 2 + n) ? 1 : 0);
            if (t >= 3 && t <= 2 + n) chk($sformatf("addr@%0d", t), rd_addr, t - 3);
            if (t < stop) tick();
        end
    endtask

    task automatic illegal(input logic [31:0] d);
        set_dims(d);
        start = 1'b1;
        tick();
        chk("ill_b0_err", err, 0);
        chk("ill_b0_busy", busy, 0);
        start = 1'b0;
        tick();
        chk("ill_b1_err", err, 1);
        chk("ill_b1_ctrl", ctrl_logic, 2);
        chk("ill_b1_busy", busy, 0);
        chk("ill_b1_rden", rd_en, 0);
        for (int t = 2; t <= 4; t++) begin
            tick();
            chk($sformatf("ill_b%0d_err", t), err, 0);
            chk($sformatf("ill_b%0d_ctrl", t), ctrl_logic, 2);
            chk($sformatf("ill_b%0d_busy", t), busy, 0);
            chk($sformatf("ill_b%0d_rden", t), rd_en, 0);
        end
    endtask

    initial begin
        fill(8'h11);
        tick();
        tick();
        chk_rst("reset");
        RST = 1'b0;
        tick();
        tick();
        chk_rst("idle");
        frame(32'h02020202, 0, 0, '1, 0);
        tick();
        chk("after1_ctrl", ctrl_logic, 2);
        chk("after1_done", done, 0);
        fill(8'h40);
        frame(32'h03020204, 0, 0, '1, 0);
        tick();
        fill(8'h11);
        frame(32'h02020202, 0, 1, 32'h02020202, 0);
        frame(32'h02020202, 1, 0, '1, 0);
        tick();
        illegal(32'h02030202);
        illegal(32'h00020202);
        illegal(32'h02020205);
        frame(32'h02020202, 0, 1, 32'h02030202, 0);
        start = 1'b0;
        tick();
        chk("gapill_err", err, 1);
        chk("gapill_busy", busy, 0);
        chk("gapill_ctrl", ctrl_logic, 2);
        tick();
        chk("gapill2_err", err, 0);
        chk("gapill2_busy", busy, 0);
        chk("gapill2_rden", rd_en, 0);
        fill(8'h80);
        frame(32'h04040404, 0, 0, '1, 10);
        #1 RST = 1'b1;
        #1 chk_rst("midrst");
        tick();
        RST = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk_rst($sformatf("postrst%0d", t));
        end
        fill(8'h11);
        frame(32'h02020202, 0, 0, '1, 0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
